stack_access_unit: RTL

//  Memory-stage controller that sits directly upstream of the data/stack memory. Takes one

---
 rtl/stack_access_unit_pkg.sv | 34 +++
 rtl/stack_access_unit_stack_pointer_reg.sv | 59 +++++
 rtl/stack_access_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/stack_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_access_unit_pkg
// Brief    : Op codes, FSM states and SP update commands for stack_access_unit.
// Revision : 1.0
// ============================================================================
package stack_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4,
        OP_CALL  = 3'd5,
        OP_RET   = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SP_HOLD = 3'd0,
        SP_INC1 = 3'd1,
        SP_DEC1 = 3'd2,
        SP_INC2 = 3'd3,
        SP_DEC2 = 3'd4
    } sp_cmd_t;

endpackage
`default_nettype wire

// File: rtl/stack_access_unit_stack_pointer_reg.sv
`default_nettype none
// ============================================================================
// Module   : stack_pointer_reg
// Brief    : Stack pointer with modulo-depth +/-1, +/-2 updates and wrap flag.
// Revision : 1.0
// ============================================================================
module stack_pointer_reg
    import stack_access_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int NUM_OF_REGISTER = 11,
    parameter int SP_RESET        = (2**NUM_OF_REGISTER) - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  sp_cmd_t                    cmd,
    output logic [ADDRESS_WIDTH-1:0]   sp,
    output logic [NUM_OF_REGISTER-1:0] sp_lo,
    output logic                       stack_fault
);

    localparam logic [NUM_OF_REGISTER-1:0] c_sp_max = '1;
    localparam logic [NUM_OF_REGISTER-1:0] c_one    = NUM_OF_REGISTER'(1);
    localparam logic [NUM_OF_REGISTER-1:0] c_two    = NUM_OF_REGISTER'(2);

    logic [NUM_OF_REGISTER-1:0] r_sp;
    logic                       r_fault;
    logic [NUM_OF_REGISTER-1:0] w_next;
    logic                       w_wrap;

    // Wrap is detected on the pre-update value; the new value simply rolls over.
    always_comb begin
        w_next = r_sp;
        w_wrap = 1'b0;
        case (cmd)
            SP_INC1: begin w_next = r_sp + c_one; w_wrap = (r_sp == c_sp_max);         end
            SP_DEC1: begin w_next = r_sp - c_one; w_wrap = (r_sp == '0);               end
            SP_INC2: begin w_next = r_sp + c_two; w_wrap = (r_sp > (c_sp_max - c_two)); end
            SP_DEC2: begin w_next = r_sp - c_two; w_wrap = (r_sp < c_two);             end
            default: begin w_next = r_sp;         w_wrap = 1'b0;                       end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp    <= NUM_OF_REGISTER'(SP_RESET);
            r_fault <= 1'b0;
        end else begin
            r_sp    <= w_next;
            r_fault <= w_wrap;
        end
    end

    assign sp          = {{(ADDRESS_WIDTH-NUM_OF_REGISTER){1'b0}}, r_sp};
    assign sp_lo       = r_sp;
    assign stack_fault = r_fault;

endmodule
`default_nettype wire

// File: rtl/stack_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : stack_access_unit
// Brief    : Memory-stage controller: LOAD/STORE/PUSH/POP and split CALL/RET.
// Revision : 1.0
// ============================================================================
module stack_access_unit
    import stack_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int NUM_OF_REGISTER = 11,
    parameter int SP_RESET        = (2**NUM_OF_REGISTER) - 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     op_valid,
    input  logic [2:0]               op,
    input  logic [ADDRESS_WIDTH-1:0] op_address,
    input  logic [DATA_WIDTH-1:0]    op_wdata,
    input  logic [ADDRESS_WIDTH-1:0] op_pc,
    output logic                     mem_write_en,
    output logic                     mem_read_en,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     stall,
    output logic [DATA_WIDTH-1:0]    load_data,
    output logic                     load_valid,
    output logic [ADDRESS_WIDTH-1:0] ret_pc,
    output logic                     ret_pc_valid,
    output logic [ADDRESS_WIDTH-1:0] sp,
    output logic                     stack_fault
);

    localparam int c_zext = ADDRESS_WIDTH - NUM_OF_REGISTER;

    state_t                     r_state;
    op_t                        r_op;
    logic [DATA_WIDTH-1:0]      r_lo_q;

    op_t                        w_op_in;
    op_t                        w_op_cur;
    state_t                     w_next_state;
    sp_cmd_t                    w_sp_cmd;
    logic [NUM_OF_REGISTER-1:0] w_sp_lo;
    logic [ADDRESS_WIDTH-1:0]   w_addr_sp, w_addr_m1, w_addr_p1, w_addr_p2;
    logic                       w_wr, w_rd, w_stall, w_load_valid, w_ret_valid;
    logic [ADDRESS_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]      w_wdata;

    stack_pointer_reg #(
        .ADDRESS_WIDTH  (ADDRESS_WIDTH),
        .NUM_OF_REGISTER(NUM_OF_REGISTER),
        .SP_RESET       (SP_RESET)
    ) u_sp (
        .clk        (clk),
        .reset      (reset),
        .cmd        (w_sp_cmd),
        .sp         (sp),
        .sp_lo      (w_sp_lo),
        .stack_fault(stack_fault)
    );

    // Stack addresses wrap within the memory depth, then zero-extend.
    assign w_addr_sp = {{c_zext{1'b0}}, w_sp_lo};
    assign w_addr_m1 = {{c_zext{1'b0}}, w_sp_lo - NUM_OF_REGISTER'(1)};
    assign w_addr_p1 = {{c_zext{1'b0}}, w_sp_lo + NUM_OF_REGISTER'(1)};
    assign w_addr_p2 = {{c_zext{1'b0}}, w_sp_lo + NUM_OF_REGISTER'(2)};

    always_comb begin
        w_op_in = op_valid ? op_t'(op) : OP_NONE;
        if (w_op_in == OP_RSVD) w_op_in = OP_NONE;
        w_op_cur = (r_state == SECOND) ? r_op : w_op_in;
    end

    always_comb begin
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        w_stall      = 1'b0;
        w_load_valid = 1'b0;
        w_ret_valid  = 1'b0;
        w_sp_cmd     = SP_HOLD;
        w_next_state = IDLE;
        case (w_op_cur)
            OP_LOAD: begin
                w_rd = 1'b1; w_addr = op_address; w_load_valid = 1'b1;
            end
            OP_STORE: begin
                w_wr = 1'b1; w_addr = op_address; w_wdata = op_wdata;
            end
            OP_PUSH: begin
                w_wr = 1'b1; w_addr = w_addr_sp; w_wdata = op_wdata; w_sp_cmd = SP_DEC1;
            end
            OP_POP: begin
                w_rd = 1'b1; w_addr = w_addr_p1; w_load_valid = 1'b1; w_sp_cmd = SP_INC1;
            end
            OP_CALL: begin
                w_wr = 1'b1;
                if (r_state == IDLE) begin
                    w_addr = w_addr_sp; w_wdata = op_pc[ADDRESS_WIDTH-1:ADDRESS_WIDTH-DATA_WIDTH];
                    w_stall = 1'b1; w_next_state = SECOND;
                end else begin
                    w_addr = w_addr_m1; w_wdata = op_pc[DATA_WIDTH-1:0]; w_sp_cmd = SP_DEC2;
                end
            end
            OP_RET: begin
                w_rd = 1'b1;
                if (r_state == IDLE) begin
                    w_addr = w_addr_p1; w_stall = 1'b1; w_next_state = SECOND;
                end else begin
                    w_addr = w_addr_p2; w_ret_valid = 1'b1; w_sp_cmd = SP_INC2;
                end
            end
            default: ;
        endcase
        // Reset squashes any in-flight access, including the second CALL write.
        if (reset) begin
            w_wr = 1'b0; w_rd = 1'b0; w_stall = 1'b0;
            w_load_valid = 1'b0; w_ret_valid = 1'b0; w_sp_cmd = SP_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= OP_NONE;
            r_lo_q  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE) r_op <= w_op_in;
            if (r_state == IDLE && w_op_cur == OP_RET) r_lo_q <= mem_rdata;
        end
    end

    assign mem_write_en = w_wr;
    assign mem_read_en  = w_rd;
    assign mem_address  = w_addr;
    assign mem_wdata    = w_wdata;
    assign stall        = w_stall;
    assign load_data    = mem_rdata;
    assign load_valid   = w_load_valid;
    assign ret_pc       = {mem_rdata, r_lo_q};
    assign ret_pc_valid = w_ret_valid;

endmodule
`default_nettype wire
